// File: rtl/alu_arb.sv
// alu_arb: two-requester arbiter feeding a shared ALU with 2 registered stages.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module alu_arb (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [3:0]  req0_ctr,
  input  logic [3:0]  req1_ctr,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [7:0]  rsp0_o,
  output logic [7:0]  rsp1_o,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_ctr,
  input  logic [7:0]  alu_o,
  output logic [15:0] op_cnt
);

  logic        gnt0, gnt1, hs;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [3:0]  alu_ctr_q, alu_ctr_d;
  logic [2:0]  tag_v_q, tag_v_d;
  logic [2:0]  tag_id_q, tag_id_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [7:0]  rsp0_o_q, rsp0_o_d;
  logic [7:0]  rsp1_o_q, rsp1_o_d;
  logic [15:0] op_cnt_q, op_cnt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic        last_q, last_d;
`endif

  // No grant while in reset, so nothing is accepted on a reset edge.
  always_comb begin : arb
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt0 = req0_valid;
      gnt1 = req1_valid & ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
`endif
    end
  end

  assign hs = gnt0 | gnt1;

  always_comb begin : datapath
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_ctr_d = alu_ctr_q;
    if (hs) begin
      alu_a_d   = gnt1 ? req1_a   : req0_a;
      alu_b_d   = gnt1 ? req1_b   : req0_b;
      alu_ctr_d = gnt1 ? req1_ctr : req0_ctr;
    end
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d = hs ? gnt1 : last_q;
`endif
    // Stage 2 lines up with the ALU output for the op it tags.
    tag_v_d      = {tag_v_q[1:0], hs};
    tag_id_d     = {tag_id_q[1:0], gnt1};
    rsp0_valid_d = tag_v_q[2] & ~tag_id_q[2];
    rsp1_valid_d = tag_v_q[2] &  tag_id_q[2];
    rsp0_o_d     = rsp0_valid_d ? alu_o : rsp0_o_q;
    rsp1_o_d     = rsp1_valid_d ? alu_o : rsp1_o_q;
    op_cnt_d     = op_cnt_q + {15'd0, tag_v_q[2]};
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctr_q    <= '0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_o_q     <= '0;
      rsp1_o_q     <= '0;
      op_cnt_q     <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q       <= 1'b1;
`endif
    end else begin
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctr_q    <= alu_ctr_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_o_q     <= rsp0_o_d;
      rsp1_o_q     <= rsp1_o_d;
      op_cnt_q     <= op_cnt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q       <= last_d;
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_o     = rsp0_o_q;
  assign rsp1_o     = rsp1_o_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctr    = alu_ctr_q;
  assign op_cnt     = op_cnt_q;

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: random and directed checks of alu_arb against a queue-based model.
// Includes a 2-stage registered ALU so results arrive two edges after alu_*.
module tb_alu_arb;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_ctr = '0, req1_ctr = '0;
  logic        rsp0_valid, rsp1_valid;
  logic [7:0]  rsp0_o, rsp1_o;
  logic [7:0]  alu_a, alu_b, alu_o;
  logic [3:0]  alu_ctr;
  logic [15:0] op_cnt;
  logic [7:0]  ar, br;
  logic [3:0]  cr;

  typedef struct {
    int         due;
    logic       id;
    logic [7:0] d;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        last_m;
  logic [15:0] cnt_m;
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_c;
  // {r0,r1,v0,v1,o0,o1,alu_a,alu_b,alu_ctr,op_cnt}
  logic [55:0] obs_vec, exp_vec;

  always #5 ck = ~ck;

  alu_arb dut (
    .ck(ck), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b),
    .req0_ctr(req0_ctr), .req1_ctr(req1_ctr),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_o(rsp0_o), .rsp1_o(rsp1_o),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_o(alu_o), .op_cnt(op_cnt)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] c);
    case (c)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      4'hB: return ~(a | b);
      4'hC: return a >> 1;
      4'hD: return a << 1;
      4'hE: return b;
      4'hF: return a;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge ck) begin
    ar    <= alu_a;
    br    <= alu_b;
    cr    <= alu_ctr;
    alu_o <= alu_f(ar, br, cr);
  end

  task automatic model_clear();
    q.delete();
    last_m = 1'b1;
    cnt_m  = '0;
    m_a    = '0;
    m_b    = '0;
    m_c    = '0;
  endtask

  // Drives one cycle, snapshots DUT outputs mid-cycle, advances the model.
  task automatic step(input logic v0, input logic v1,
                      input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] c0,
                      input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] c1);
    logic       w, any, e_v0, e_v1;
    logic [7:0] o0, o1;
    exp_t       e;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req0_ctr = c0;
    req1_a = a1; req1_b = b1; req1_ctr = c1;
    @(negedge ck);
    cyc++;
    any = v0 | v1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    w = !v0;
`else
    w = (v0 && v1) ? !last_m : v1;
`endif
    e_v0 = 1'b0; e_v1 = 1'b0; o0 = '0; o1 = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      cnt_m++;
      if (e.id) begin e_v1 = 1'b1; o1 = e.d; end
      else begin e_v0 = 1'b1; o0 = e.d; end
    end
    exp_vec = {any && !w, any && w, e_v0, e_v1, o0, o1, m_a, m_b, m_c, cnt_m};
    obs_vec = {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_valid ? rsp0_o : 8'h00, rsp1_valid ? rsp1_o : 8'h00,
               alu_a, alu_b, alu_ctr, op_cnt};
    if (any) begin
      last_m = w;
      m_a = w ? a1 : a0;
      m_b = w ? b1 : b0;
      m_c = w ? c1 : c0;
      e.due = cyc + 4;
      e.id  = w;
      e.d   = alu_f(m_a, m_b, m_c);
      q.push_back(e);
    end
    @(posedge ck);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom),
         8'($urandom), 8'($urandom), 4'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'hAA; req0_b = 8'h55; req0_ctr = 4'h3;
    req1_a = 8'h5A; req1_b = 8'hA5; req1_ctr = 4'hC;
    repeat (3) @(posedge ck);
    @(negedge ck);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_o, rsp1_o,
         alu_a, alu_b, alu_ctr, op_cnt} !== 56'd0) begin
      errors++;
      $display("FAIL reset_values got=%b%b%b%b %h %h %h %h %h %h required all zero",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_o, rsp1_o,
               alu_a, alu_b, alu_ctr, op_cnt);
    end
    @(posedge ck);
    #1;
    rst_n = 1'b1;
    model_clear();
    step(1'b1, 1'b1, 8'h11, 8'h22, 4'h0, 8'h33, 8'h44, 4'h1);
    checks++;
    if (obs_vec[55:54] !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_grant got=%b required=10", obs_vec[55:54]);
    end
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL reset_first cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
    end
    repeat (5) begin
      idle_step();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 1'b0, 8'h05, 8'h03, 4'h0, 8'h77, 8'h66, 4'h9);
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
    end
    repeat (6) begin
      idle_step();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL single_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
    if (op_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_op_cnt got=%h required=0001", op_cnt);
    end
  endtask

  task automatic test_contention();
    int n1;
    n1 = 0;
    do_reset();
    repeat (12) begin
      step(1'b1, 1'b1, 8'h10, 8'h03, 4'h1, 8'hF0, 8'h3C, 4'h8);
      n1 += int'(obs_vec[54]);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL contention cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    repeat (5) begin
      idle_step();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL contention_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (n1 !== 0) begin
`else
    if (n1 !== 6) begin
`endif
      errors++;
      $display("FAIL contention_req1_grants got=%0d", n1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    int first_c, last_c;
    first_c = -1;
    last_c  = -1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 4) step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 4'($urandom),
                      8'(1 << i), 8'($urandom), 4'hD);
      else idle_step();
      if (obs_vec[52]) begin
        got.push_back(obs_vec[43:36]);
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
    if (got.size() != 4 || last_c - first_c != 3 || got[0] !== 8'h02 ||
        got[1] !== 8'h04 || got[2] !== 8'h08 || got[3] !== 8'h10) begin
      errors++;
      $display("FAIL back_to_back_seq got %0d strobes over %0d cycles, required 02,04,08,10 consecutive",
               got.size(), last_c - first_c + 1);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    step(1'b1, 1'b0, 8'hFF, 8'hFF, 4'h4, 8'h01, 8'h01, 4'h0);
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++;
      $display("FAIL illegal cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
    end
    repeat (5) begin
      idle_step();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL illegal_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
    if (op_cnt !== 16'd1) begin
      errors++;
      $display("FAIL illegal_op_cnt got=%h required=0001", op_cnt);
    end
    for (int c = 2; c < 12; c++) begin
      if (c < 8) step(c[0], ~c[0], 8'($urandom), 8'($urandom), 4'(c),
                      8'($urandom), 8'($urandom), 4'(c));
      else idle_step();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL illegal_codes cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(1'b1, 1'b0, 8'h21, 8'h12, 4'h0, 8'h00, 8'h00, 4'h0);
      else if (i == 1) step(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 8'h30, 8'h03, 4'h1);
      else idle_step();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL midflight_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    do_reset();
    repeat (6) begin
      idle_step();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL midflight_post cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
    if (op_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midflight_op_cnt got=%h required=0000", op_cnt);
    end
    step(1'b1, 1'b1, 8'h01, 8'h02, 4'h0, 8'h03, 8'h04, 4'h0);
    checks++;
    if (obs_vec[55:54] !== 2'b10) begin
      errors++;
      $display("FAIL midflight_first_grant got=%b required=10", obs_vec[55:54]);
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (3000) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           8'($urandom), 8'($urandom), 4'($urandom),
           8'($urandom), 8'($urandom), 4'($urandom));
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 65541; i++) begin
      if (i < 65536) step(1'b1, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom),
                          8'($urandom), 8'($urandom), 4'($urandom));
      else idle_step();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
    end
    checks++;
    if (op_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_op_cnt got=%h required=0000", op_cnt);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_illegal();
    test_reset_midflight();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
